// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control unit: a state machine plus per-state datapath controls.
// It also provides an illegal-opcode pulse and a counter of completed instructions.
module multicycle_control (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode_i,
    input  logic        mem_ready_i,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        mem_to_reg,
    output logic        reg_dst,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  pc_source,
    output logic [3:0]  state_o,
    output logic        illegal_o,
    output logic [31:0] instr_count_o
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXECUTE   = 4'd6,
        ALU_WB    = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        ADDI_EXEC = 4'd10,
        ADDI_WB   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t      state;
    logic [31:0] count;
    logic        legal_op;

    always_comb begin
        case (opcode_i)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: legal_op = 1'b1;
            default:                                       legal_op = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
            count <= '0;
        end else begin
            case (state)
                FETCH:     if (mem_ready_i) state <= DECODE;
                DECODE: begin
                    case (opcode_i)
                        OP_RTYPE:     state <= EXECUTE;
                        OP_LW, OP_SW: state <= MEM_ADDR;
                        OP_BEQ:       state <= BRANCH;
                        OP_J:         state <= JUMP;
                        OP_ADDI:      state <= ADDI_EXEC;
                        default:      state <= FETCH;
                    endcase
                end
                MEM_ADDR:  state <= (opcode_i == OP_LW) ? MEM_READ : MEM_WRITE;
                MEM_READ:  if (mem_ready_i) state <= MEM_WB;
                MEM_WRITE: begin
                    if (mem_ready_i) begin
                        state <= FETCH;
                        count <= count + 32'd1;
                    end
                end
                EXECUTE:   state <= ALU_WB;
                ADDI_EXEC: state <= ADDI_WB;
                MEM_WB, ALU_WB, ADDI_WB, BRANCH, JUMP: begin
                    state <= FETCH;
                    count <= count + 32'd1;
                end
                default:   state <= FETCH;
            endcase
        end
    end

    // Controls decode from the current state; reset gates them so FETCH does not drive memory while held.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        if (reset) begin
            case (state)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready_i;
                    pc_write  = mem_ready_i;
                end
                DECODE:   alu_src_b = 2'b11;
                MEM_ADDR, ADDI_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                MEM_READ: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                MEM_WB: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                end
                MEM_WRITE: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                EXECUTE: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                ALU_WB: begin
                    reg_dst   = 1'b1;
                    reg_write = 1'b1;
                end
                ADDI_WB:  reg_write = 1'b1;
                BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                end
                JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                end
                default: ;
            endcase
        end
    end

    assign illegal_o     = reset && (state == DECODE) && !legal_op;
    assign state_o       = state;
    assign instr_count_o = count;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: each instruction expands into its expected state trace.
// Randomized opcodes and memory waits are checked cycle by cycle against that trace.
module tb_multicycle_control;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  opcode = '0;
    logic        mem_ready = 1'b0;
    logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic        mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [3:0]  state;
    logic        illegal;
    logic [31:0] instr_count;
    logic [15:0] ctrl;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_count = '0;

    multicycle_control dut (
        .clk(clk), .reset(reset), .opcode_i(opcode), .mem_ready_i(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .state_o(state), .illegal_o(illegal),
        .instr_count_o(instr_count)
    );

    always #5 clk = ~clk;

    assign ctrl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_legal(input logic [5:0] op);
        return op == OP_RTYPE || op == OP_LW || op == OP_SW ||
               op == OP_BEQ || op == OP_J || op == OP_ADDI;
    endfunction

    // Control table indexed by state code, packed in the same order as ctrl.
    function automatic logic [15:0] exp_ctrl(input int st, input logic rdy);
        logic pw = 0, pwc = 0, iod = 0, mr = 0, mw = 0, irw = 0, m2r = 0, rd = 0, rw = 0, asa = 0;
        logic [1:0] asb = 0, aop = 0, ps = 0;
        case (st)
            0:       begin mr = 1; asb = 2'b01; irw = rdy; pw = rdy; end
            1:       asb = 2'b11;
            2, 10:   begin asa = 1; asb = 2'b10; end
            3:       begin mr = 1; iod = 1; end
            4:       begin m2r = 1; rw = 1; end
            5:       begin mw = 1; iod = 1; end
            6:       begin asa = 1; aop = 2'b10; end
            7:       begin rd = 1; rw = 1; end
            11:      rw = 1;
            8:       begin asa = 1; aop = 2'b01; pwc = 1; ps = 2'b01; end
            9:       begin pw = 1; ps = 2'b10; end
            default: ;
        endcase
        return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, asb, aop, ps};
    endfunction

    // Called at posedge+1 with the DUT in FETCH; returns at posedge+1 after the instruction retires.
    task automatic run_instr(input logic [5:0] op, input int wf, input int wm);
        int   sq[$];
        logic rq[$];
        for (int i = 0; i < wf; i++) begin sq.push_back(0); rq.push_back(1'b0); end
        sq.push_back(0); rq.push_back(1'b1);
        sq.push_back(1); rq.push_back(1'($urandom));
        case (op)
            OP_LW: begin
                sq.push_back(2); rq.push_back(1'($urandom));
                for (int i = 0; i < wm; i++) begin sq.push_back(3); rq.push_back(1'b0); end
                sq.push_back(3); rq.push_back(1'b1);
                sq.push_back(4); rq.push_back(1'($urandom));
            end
            OP_SW: begin
                sq.push_back(2); rq.push_back(1'($urandom));
                for (int i = 0; i < wm; i++) begin sq.push_back(5); rq.push_back(1'b0); end
                sq.push_back(5); rq.push_back(1'b1);
            end
            OP_RTYPE: begin sq.push_back(6); rq.push_back(1'($urandom)); sq.push_back(7); rq.push_back(1'($urandom)); end
            OP_ADDI:  begin sq.push_back(10); rq.push_back(1'($urandom)); sq.push_back(11); rq.push_back(1'($urandom)); end
            OP_BEQ:   begin sq.push_back(8); rq.push_back(1'($urandom)); end
            OP_J:     begin sq.push_back(9); rq.push_back(1'($urandom)); end
            default: ;
        endcase
        for (int i = 0; i < sq.size(); i++) begin
            mem_ready = rq[i];
            opcode = (sq[i] == 1 || sq[i] == 2) ? op : 6'($urandom);
            #1;
            check($sformatf("state op=%b step%0d", op, i), 32'(state), 32'(sq[i]));
            check($sformatf("ctrl op=%b st=%0d", op, sq[i]), 32'(ctrl), 32'(exp_ctrl(sq[i], rq[i])));
            check($sformatf("illegal op=%b st=%0d", op, sq[i]), 32'(illegal),
                  32'(sq[i] == 1 && !is_legal(op)));
            check("mem_rd_wr_excl", 32'(mem_read & mem_write), 32'd0);
            check("rw_mw_excl", 32'(reg_write & mem_write), 32'd0);
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b0;
        if (is_legal(op)) exp_count = exp_count + 32'd1;
        check($sformatf("count op=%b", op), instr_count, exp_count);
        check("back_to_fetch", 32'(state), 32'd0);
    endtask

    initial begin
        logic [5:0] op;
        logic [5:0] legal_ops [6];
        legal_ops = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};

        mem_ready = 1'b1;
        #3;
        check("rst_state", 32'(state), 32'd0);
        check("rst_ctrl", 32'(ctrl), 32'd0);
        check("rst_count", instr_count, 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_state", 32'(state), 32'd0);
        check("rst_hold_ctrl", 32'(ctrl), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;

        // Directed: lw, sw with write stalls, illegal opcode, then R/beq/j/addi.
        run_instr(OP_LW, 0, 0);
        run_instr(OP_SW, 0, 3);
        run_instr(6'b111111, 0, 0);
        run_instr(OP_RTYPE, 0, 0);
        run_instr(OP_BEQ, 0, 0);
        run_instr(OP_J, 0, 0);
        run_instr(OP_ADDI, 0, 0);

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                do op = 6'($urandom); while (is_legal(op));
            end else begin
                op = legal_ops[$urandom_range(0, 5)];
            end
            run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Reset pulsed between edges while an lw waits in MEM_READ.
        opcode = OP_LW;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        check("abort_pre_state", 32'(state), 32'd3);
        check("abort_pre_mem_read", 32'(mem_read), 32'd1);
        reset = 1'b0;
        #1;
        check("abort_state", 32'(state), 32'd0);
        check("abort_ctrl", 32'(ctrl), 32'd0);
        check("abort_count", instr_count, 32'd0);
        check("abort_illegal", 32'(illegal), 32'd0);
        exp_count = '0;
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_restart_state", 32'(state), 32'd0);
        run_instr(OP_J, 0, 0);

        // Counter wrap: preload all-ones, then retire one jump.
        dut.count = 32'hFFFF_FFFF;
        exp_count = 32'hFFFF_FFFF;
        #1;
        check("preload_count", instr_count, 32'hFFFF_FFFF);
        run_instr(OP_J, 0, 0);
        check("wrap_count", instr_count, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports clk and reset.
REQ-002 Port list SHALL be (name direction width meaning):
- clk  in  1  rising-edge clock
- reset  in  1  async active-low reset
- opcode_i  in  6  instruction[31:26] from instruction register
- mem_ready_i  in  1  memory access completes this cycle
- pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a  out  1 each  datapath controls
- alu_src_b, alu_op, pc_source  out  2 each  datapath mux/ALU selects
- state_o  out  4  current state code
- illegal_o  out  1  one-cycle pulse, unsupported opcode
- instr_count_o  out  32  completed-instruction counter

Function
REQ-003 States/codes SHALL be: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXECUTE 6, ALU_WB 7, BRANCH 8, JUMP 9, ADDI_EXEC 10, ADDI_WB 11; codes 12-15 unreachable, SHALL go to FETCH next cycle with all controls 0.
REQ-004 FETCH SHALL hold while mem_ready_i=0; on mem_ready_i=1 -> DECODE.
REQ-005 DECODE -> by opcode_i: 000000 EXECUTE; 100011 or 101011 MEM_ADDR; 000100 BRANCH; 000010 JUMP; 001000 ADDI_EXEC; any other FETCH with illegal_o=1 for that DECODE cycle only.
REQ-006 MEM_ADDR -> MEM_READ if opcode_i=100011, else MEM_WRITE.
REQ-007 MEM_READ SHALL hold while mem_ready_i=0, then -> MEM_WB; MEM_WRITE SHALL hold while mem_ready_i=0, then -> FETCH.
REQ-008 MEM_WB, ALU_WB, ADDI_WB, BRANCH, JUMP -> FETCH; EXECUTE -> ALU_WB; ADDI_EXEC -> ADDI_WB.
REQ-009 Controls SHALL be decoded from current state (unlisted = 0):
- FETCH: mem_read=1, alu_src_b=01; ir_write=pc_write=mem_ready_i (only qualified outputs)
- DECODE: alu_src_b=11
- MEM_ADDR, ADDI_EXEC: alu_src_a=1, alu_src_b=10
- MEM_READ: mem_read=1, i_or_d=1
- MEM_WB: mem_to_reg=1, reg_write=1
- MEM_WRITE: mem_write=1, i_or_d=1
- EXECUTE: alu_src_a=1, alu_op=10
- ALU_WB: reg_dst=1, reg_write=1
- ADDI_WB: reg_write=1
- BRANCH: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01
- JUMP: pc_write=1, pc_source=10
REQ-010 mem_read and mem_write SHALL never be 1 in the same cycle; reg_write SHALL never coincide with mem_write.
REQ-011 instr_count_o SHALL increment by 1 on the clock edge leaving MEM_WB, MEM_WRITE, ALU_WB, ADDI_WB, BRANCH, JUMP; illegal opcodes SHALL NOT count; wraps 0xFFFFFFFF -> 0.
REQ-012 With mem_ready_i held 1, cycles per instruction SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
REQ-013 opcode_i SHALL be sampled only in DECODE and MEM_ADDR; changes elsewhere SHALL have no effect.

Reset
REQ-014 While reset=0: state=FETCH, instr_count_o=0, illegal_o=0, immediately regardless of clk.
REQ-015 While reset=0 all control outputs SHALL be forced 0 (including FETCH mem_read/alu_src_b).
REQ-016 Reset asserted mid-instruction SHALL abort it: no further control pulses, count not incremented; after release, first edge evaluates FETCH.

Verification
REQ-017 Reset then mem_ready_i=1, opcode 100011 -> states 0,1,2,3,4,0; reg_write=1 with mem_to_reg=1 in state 4 only; instr_count_o=1.
REQ-018 opcode 101011, mem_ready_i=0 for 3 cycles in MEM_WRITE -> state 5 held 4 cycles with mem_write=1, then FETCH; reg_write never 1.
REQ-019 opcode 111111 -> DECODE then FETCH, illegal_o=1 exactly one cycle, instr_count_o unchanged.
REQ-020 Sequence R-type, beq, j, addi (ready=1) -> 14 cycles from first FETCH, instr_count_o=4, pc_source 01 in BRANCH, 10 in JUMP.
REQ-021 reset pulsed low in MEM_READ between edges -> outputs 0 and state_o=0 immediately; count 0.
REQ-022 Preload counter to 0xFFFFFFFF via 2^32-1 completions (or force) then one j -> instr_count_o=0.
